// File: rtl/fpu_interco_pkg.sv
// Shared types and helpers for the multi-channel FPU request interconnect.
// The payload struct here uses the default widths; the top builds its own with its parameters.
package fpu_interco_pkg;

    localparam int unsigned DEF_NB_APU_ARGS      = 3;
    localparam int unsigned DEF_DATA_WIDTH       = 32;
    localparam int unsigned DEF_APU_OPCODE_WIDTH = 6;
    localparam int unsigned DEF_FLAG_WIDTH       = 15;
    localparam int unsigned DEF_ID_WIDTH         = 3;

    typedef struct packed {
        logic [DEF_NB_APU_ARGS-1:0][DEF_DATA_WIDTH-1:0] operands;
        logic [DEF_APU_OPCODE_WIDTH-1:0]                op;
        logic [DEF_FLAG_WIDTH-1:0]                      flag;
        logic [DEF_ID_WIDTH-1:0]                        id;
    } fpu_req_payload_t;

    function automatic int unsigned core_to_chan(input int unsigned core_idx, input int unsigned nb_fpu);
        return core_idx % nb_fpu;
    endfunction

    function automatic int unsigned chan_core_count(input int unsigned nb_cores, input int unsigned nb_fpu,
                                                    input int unsigned chan);
        return (nb_cores - chan + nb_fpu - 1) / nb_fpu;
    endfunction

endpackage

// File: rtl/fpu_req_arbiter_mc_chk.sv
// Simulation checks for the multi-channel FPU request arbiter: response tag range,
// counter underflow and request stability while the FPU back-pressures.
module fpu_req_arbiter_mc_chk #(
    parameter int unsigned NB_CORES = 8,
    parameter int unsigned NB_FPU   = 2,
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned PW       = 8
) (
    input logic                             clk,
    input logic                             rst_n,
    input logic [NB_FPU-1:0]                fpu_req,
    input logic [NB_FPU-1:0]                fpu_gnt,
    input logic [NB_FPU-1:0][PW-1:0]        fpu_payload,
    input logic [NB_FPU-1:0]                r_valid,
    input logic [NB_FPU-1:0][ID_WIDTH-1:0]  r_id,
    input logic [NB_CORES-1:0]              resp_hit,
    input logic [NB_CORES-1:0]              cnt_zero
);

    for (genvar c = 0; c < NB_FPU; c++) begin : g_chan
        a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
            r_valid[c] |-> (int'(r_id[c]) < NB_CORES));
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (fpu_req[c] && !fpu_gnt[c]) |=> (fpu_req[c] && $stable(fpu_payload[c])));
    end

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            resp_hit[i] |-> !cnt_zero[i]);
    end

endmodule

// File: rtl/fpu_rr_arb_chan.sv
// One FPU channel: round-robin arbiter over the channel's cores plus the registered request slot.
// The slot refills in the same cycle the FPU accepts, giving one request per cycle.
module fpu_rr_arb_chan
    import fpu_interco_pkg::*;
#(
    parameter int unsigned NB_LOCAL  = 4,
    parameter type         payload_t = fpu_req_payload_t
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic     [NB_LOCAL-1:0]   core_elig,
    input  payload_t [NB_LOCAL-1:0]   core_payload,
    output logic     [NB_LOCAL-1:0]   core_gnt,
    input  logic                      fpu_gnt,
    output logic                      fpu_req,
    output payload_t                  fpu_payload
);

    localparam int unsigned PTR_W = (NB_LOCAL > 1) ? $clog2(NB_LOCAL) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] win_s;
    logic             found_s;
    logic             slot_free_s;
    logic             req_r;
    payload_t         payload_r;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = int'(base) + off;
        return PTR_W'(sum % NB_LOCAL);
    endfunction

    assign slot_free_s = !req_r || fpu_gnt;
    assign fpu_req     = req_r;
    assign fpu_payload = payload_r;

    // First eligible local core at or after the pointer, wrapping
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int j = 0; j < NB_LOCAL; j++) begin
            if (!found_s && core_elig[wrap_idx(ptr_r, unsigned'(j))]) begin
                found_s = 1'b1;
                win_s   = wrap_idx(ptr_r, unsigned'(j));
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant decode for the winner when the slot can take a new request
    always_comb begin
        core_gnt = '0;
        for (int k = 0; k < NB_LOCAL; k++) begin
            core_gnt[k] = slot_free_s && found_s && (win_s == PTR_W'(k));
        end
    end

    // Output slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r     <= 1'b0;
            payload_r <= '0;
            ptr_r     <= '0;
        end else if (slot_free_s) begin
            if (found_s) begin
                req_r     <= 1'b1;
                payload_r <= core_payload[win_s];
                ptr_r     <= (win_s == PTR_W'(NB_LOCAL - 1)) ? '0 : win_s + PTR_W'(1);
            end else begin
                req_r     <= 1'b0;
            end
        end else begin
            req_r <= req_r;
        end
    end

endmodule

// File: rtl/fpu_req_arbiter_mc.sv
// Multi-channel shared-FPU request interconnect: core i is served by channel i % NB_FPU.
// Optional per-channel stall counters are built when FPU_REQ_ARB_PERF_CNT_EN is defined.
module fpu_req_arbiter_mc
    import fpu_interco_pkg::*;
#(
    parameter int unsigned NB_CORES         = 8,
    parameter int unsigned NB_FPU           = 2,
    parameter int unsigned NB_APU_ARGS      = 3,
    parameter int unsigned APU_OPCODE_WIDTH = 6,
    parameter int unsigned FLAG_WIDTH       = 15,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned MAX_OUTSTANDING  = 2,
    parameter int unsigned ID_WIDTH         = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NB_CORES-1:0]                               core_req_i,
    input  logic [NB_CORES-1:0][NB_APU_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES-1:0][APU_OPCODE_WIDTH-1:0]         core_op_i,
    input  logic [NB_CORES-1:0][FLAG_WIDTH-1:0]               core_flag_i,
    output logic [NB_CORES-1:0]                               core_gnt_o,
    output logic [NB_CORES-1:0]                               core_r_valid_o,
    output logic [NB_FPU-1:0]                                 fpu_req_o,
    output logic [NB_FPU-1:0][NB_APU_ARGS-1:0][DATA_WIDTH-1:0] fpu_operands_o,
    output logic [NB_FPU-1:0][APU_OPCODE_WIDTH-1:0]           fpu_op_o,
    output logic [NB_FPU-1:0][FLAG_WIDTH-1:0]                 fpu_flag_o,
    output logic [NB_FPU-1:0][ID_WIDTH-1:0]                   fpu_id_o,
    input  logic [NB_FPU-1:0]                                 fpu_gnt_i,
    input  logic [NB_FPU-1:0]                                 fpu_r_valid_i,
    input  logic [NB_FPU-1:0][ID_WIDTH-1:0]                   fpu_r_id_i
`ifdef FPU_REQ_ARB_PERF_CNT_EN
    ,
    output logic [NB_FPU-1:0][31:0]                           perf_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned MAX_LOCAL = (NB_CORES + NB_FPU - 1) / NB_FPU;

    typedef struct packed {
        logic [NB_APU_ARGS-1:0][DATA_WIDTH-1:0] operands;
        logic [APU_OPCODE_WIDTH-1:0]            op;
        logic [FLAG_WIDTH-1:0]                  flag;
        logic [ID_WIDTH-1:0]                    id;
    } payload_t;

    logic [NB_CORES-1:0]                 gnt_s;
    logic [NB_CORES-1:0]                 rvalid_s;
    logic [NB_CORES-1:0]                 cnt_zero_s;
    logic [CNT_W-1:0]                    cnt_r [NB_CORES];
    logic [NB_FPU-1:0][MAX_LOCAL-1:0]    chan_elig_s;
    logic [NB_FPU-1:0][MAX_LOCAL-1:0]    chan_gnt_s;
    payload_t [NB_FPU-1:0][MAX_LOCAL-1:0] chan_in_s;
    payload_t [NB_FPU-1:0]               chan_out_s;

    // Reset gating keeps the combinational core-side outputs quiet during reset
    assign core_gnt_o     = gnt_s & {NB_CORES{rst_n}};
    assign core_r_valid_o = rvalid_s & {NB_CORES{rst_n}};

    for (genvar i = 0; i < NB_CORES; i++) begin : g_core
        localparam int unsigned C = core_to_chan(i, NB_FPU);
        localparam int unsigned K = i / NB_FPU;
        assign chan_elig_s[C][K] = core_req_i[i] && (cnt_r[i] < CNT_W'(MAX_OUTSTANDING));
        assign chan_in_s[C][K]   = '{operands: core_operands_i[i], op: core_op_i[i],
                                     flag: core_flag_i[i], id: ID_WIDTH'(i)};
        assign gnt_s[i]          = chan_gnt_s[C][K];
        assign cnt_zero_s[i]     = (cnt_r[i] == '0);
    end

    for (genvar c = 0; c < NB_FPU; c++) begin : g_chan
        localparam int unsigned NL = chan_core_count(NB_CORES, NB_FPU, c);

        fpu_rr_arb_chan #(
            .NB_LOCAL  (NL),
            .payload_t (payload_t)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .core_elig    (chan_elig_s[c][NL-1:0]),
            .core_payload (chan_in_s[c][NL-1:0]),
            .core_gnt     (chan_gnt_s[c][NL-1:0]),
            .fpu_gnt      (fpu_gnt_i[c]),
            .fpu_req      (fpu_req_o[c]),
            .fpu_payload  (chan_out_s[c])
        );

        for (genvar k = NL; k < MAX_LOCAL; k++) begin : g_pad
            assign chan_elig_s[c][k] = 1'b0;
            assign chan_in_s[c][k]   = '0;
            assign chan_gnt_s[c][k]  = 1'b0;
        end

        assign fpu_operands_o[c] = chan_out_s[c].operands;
        assign fpu_op_o[c]       = chan_out_s[c].op;
        assign fpu_flag_o[c]     = chan_out_s[c].flag;
        assign fpu_id_o[c]       = chan_out_s[c].id;
    end

    // Tagged responses decoded back to per-core valids
    always_comb begin
        rvalid_s = '0;
        for (int c = 0; c < NB_FPU; c++) begin
            for (int i = 0; i < NB_CORES; i++) begin
                if (fpu_r_valid_i[c] && (fpu_r_id_i[c] == ID_WIDTH'(i))) begin
                    rvalid_s[i] = 1'b1;
                end else begin
                    rvalid_s[i] = rvalid_s[i];
                end
            end
        end
    end

    // Per-core in-flight counters; an unexpected response saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_CORES; i++) cnt_r[i] <= '0;
        end else begin
            for (int i = 0; i < NB_CORES; i++) begin
                case ({gnt_s[i], rvalid_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    2'b01:   cnt_r[i] <= (cnt_r[i] != '0) ? cnt_r[i] - CNT_W'(1) : '0;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

`ifdef FPU_REQ_ARB_PERF_CNT_EN
    logic [NB_FPU-1:0][MAX_LOCAL-1:0] chan_creq_s;
    logic [NB_FPU-1:0][31:0]          perf_r;

    for (genvar i = 0; i < NB_CORES; i++) begin : g_perf_core
        assign chan_creq_s[core_to_chan(i, NB_FPU)][i / NB_FPU] = core_req_i[i];
    end
    for (genvar c = 0; c < NB_FPU; c++) begin : g_perf_pad
        for (genvar k = chan_core_count(NB_CORES, NB_FPU, c); k < MAX_LOCAL; k++) begin : g_pad
            assign chan_creq_s[c][k] = 1'b0;
        end
    end

    // Stall cycles: some requester in the channel left without a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= '0;
        end else begin
            for (int c = 0; c < NB_FPU; c++) begin
                if (|(chan_creq_s[c] & ~chan_gnt_s[c])) perf_r[c] <= perf_r[c] + 32'd1;
                else                                    perf_r[c] <= perf_r[c];
            end
        end
    end
    assign perf_stall_cnt_o = perf_r;
`endif

    fpu_req_arbiter_mc_chk #(
        .NB_CORES (NB_CORES),
        .NB_FPU   (NB_FPU),
        .ID_WIDTH (ID_WIDTH),
        .PW       ($bits(payload_t))
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .fpu_req     (fpu_req_o),
        .fpu_gnt     (fpu_gnt_i),
        .fpu_payload (chan_out_s),
        .r_valid     (fpu_r_valid_i),
        .r_id        (fpu_r_id_i),
        .resp_hit    (rvalid_s),
        .cnt_zero    (cnt_zero_s)
    );

endmodule

// File: tb/tb_fpu_req_arbiter_mc.sv
// Directed, table-driven bench for fpu_req_arbiter_mc with 8 cores on 2 FPU channels.
module tb_fpu_req_arbiter_mc;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [7:0]                  core_req;
    logic [7:0][2:0][31:0]       core_operands;
    logic [7:0][5:0]             core_op;
    logic [7:0][14:0]            core_flag;
    logic [7:0]                  core_gnt;
    logic [7:0]                  core_r_valid;
    logic [1:0]                  fpu_req;
    logic [1:0][2:0][31:0]       fpu_operands;
    logic [1:0][5:0]             fpu_op;
    logic [1:0][14:0]            fpu_flag;
    logic [1:0][2:0]             fpu_id;
    logic [1:0]                  fpu_gnt;
    logic [1:0]                  fpu_r_valid;
    logic [1:0][2:0]             fpu_r_id;
`ifdef FPU_REQ_ARB_PERF_CNT_EN
    logic [1:0][31:0]            perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fpu_req_arbiter_mc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_i      (core_req),
        .core_operands_i (core_operands),
        .core_op_i       (core_op),
        .core_flag_i     (core_flag),
        .core_gnt_o      (core_gnt),
        .core_r_valid_o  (core_r_valid),
        .fpu_req_o       (fpu_req),
        .fpu_operands_o  (fpu_operands),
        .fpu_op_o        (fpu_op),
        .fpu_flag_o      (fpu_flag),
        .fpu_id_o        (fpu_id),
        .fpu_gnt_i       (fpu_gnt),
        .fpu_r_valid_i   (fpu_r_valid),
        .fpu_r_id_i      (fpu_r_id)
`ifdef FPU_REQ_ARB_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [1:0] fgnt;
        logic [1:0] rv;
        logic [2:0] rid0;
        logic [2:0] rid1;
        logic       mut1;
        logic [7:0] e_gnt;
        logic [1:0] e_freq;
        logic [2:0] e_id0;
        logic [2:0] e_id1;
        logic [7:0] e_rv;
    } vec_t;

    vec_t vecs [29];

    function automatic logic [5:0] op_of(input int i);
        return 6'(i * 5 + 3);
    endfunction
    function automatic logic [31:0] opnd_of(input int i, input int a);
        return 32'hA000_0000 | (32'(i) << 8) | 32'(a);
    endfunction
    function automatic logic [14:0] flag_of(input int i);
        return 15'(i * 3 + 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_core_data(input logic mut1);
        for (int i = 0; i < 8; i++) begin
            core_op[i]   = op_of(i);
            core_flag[i] = flag_of(i);
            for (int a = 0; a < 3; a++) core_operands[i][a] = opnd_of(i, a);
        end
        if (mut1) begin
            core_op[1]          = 6'h3F;
            core_flag[1]        = 15'h7FFF;
            core_operands[1][2] = 32'hDEAD_BEEF;
        end
    endtask

    initial begin
        //          req    fgnt   rv     rid0  rid1  mut   e_gnt  e_freq e_id0 e_id1 e_rv
        vecs[0]  = '{8'h55, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h01, 2'b00, 3'd0, 3'd0, 8'h00};
        vecs[1]  = '{8'h55, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h04, 2'b01, 3'd0, 3'd0, 8'h00};
        vecs[2]  = '{8'h55, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h10, 2'b01, 3'd2, 3'd0, 8'h00};
        vecs[3]  = '{8'h55, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h40, 2'b01, 3'd4, 3'd0, 8'h00};
        vecs[4]  = '{8'h55, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h01, 2'b01, 3'd6, 3'd0, 8'h00};
        vecs[5]  = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b01, 3'd0, 3'd0, 8'h00};
        vecs[6]  = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b00, 3'd0, 3'd0, 8'h00};
        vecs[7]  = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b0, 8'h02, 2'b00, 3'd0, 3'd0, 8'h00};
        vecs[8]  = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[9]  = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[10] = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[11] = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[12] = '{8'h02, 2'b01, 2'b00, 3'd0, 3'd0, 1'b1, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[13] = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b10, 3'd0, 3'd1, 8'h00};
        vecs[14] = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b00, 3'd0, 3'd1, 8'h00};
        vecs[15] = '{8'h08, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h08, 2'b00, 3'd0, 3'd1, 8'h00};
        vecs[16] = '{8'h08, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h08, 2'b10, 3'd0, 3'd3, 8'h00};
        vecs[17] = '{8'h08, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b10, 3'd0, 3'd3, 8'h00};
        vecs[18] = '{8'h08, 2'b11, 2'b10, 3'd0, 3'd3, 1'b0, 8'h00, 2'b00, 3'd0, 3'd3, 8'h08};
        vecs[19] = '{8'h08, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h08, 2'b00, 3'd0, 3'd3, 8'h00};
        vecs[20] = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b10, 3'd0, 3'd3, 8'h00};
        vecs[21] = '{8'h20, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h20, 2'b00, 3'd0, 3'd3, 8'h00};
        vecs[22] = '{8'h20, 2'b11, 2'b10, 3'd0, 3'd5, 1'b0, 8'h20, 2'b10, 3'd0, 3'd5, 8'h20};
        vecs[23] = '{8'h20, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h20, 2'b10, 3'd0, 3'd5, 8'h00};
        vecs[24] = '{8'h20, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b10, 3'd0, 3'd5, 8'h00};
        vecs[25] = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b00, 3'd0, 3'd5, 8'h00};
        vecs[26] = '{8'h80, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h80, 2'b00, 3'd0, 3'd5, 8'h00};
        vecs[27] = '{8'h00, 2'b11, 2'b11, 3'd2, 3'd7, 1'b0, 8'h00, 2'b10, 3'd0, 3'd7, 8'h84};
        vecs[28] = '{8'h00, 2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 2'b00, 3'd0, 3'd7, 8'h00};

        // Reset state, with every core requesting
        rst_n       = 1'b0;
        core_req    = 8'hFF;
        fpu_gnt     = 2'b11;
        fpu_r_valid = 2'b00;
        fpu_r_id    = '0;
        load_core_data(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(core_gnt), 32'h0);
        check("rst_freq", 32'(fpu_req), 32'h0);
        check("rst_id", 32'(fpu_id), 32'h0);
        check("rst_op", 32'(fpu_op), 32'h0);
        core_req = 8'h00;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 29; n++) begin
            core_req    = vecs[n].req;
            fpu_gnt     = vecs[n].fgnt;
            fpu_r_valid = vecs[n].rv;
            fpu_r_id[0] = vecs[n].rid0;
            fpu_r_id[1] = vecs[n].rid1;
            load_core_data(vecs[n].mut1);
            @(negedge clk);
            check($sformatf("v%0d_gnt", n), 32'(core_gnt), 32'(vecs[n].e_gnt));
            check($sformatf("v%0d_freq", n), 32'(fpu_req), 32'(vecs[n].e_freq));
            check($sformatf("v%0d_id0", n), 32'(fpu_id[0]), 32'(vecs[n].e_id0));
            check($sformatf("v%0d_id1", n), 32'(fpu_id[1]), 32'(vecs[n].e_id1));
            check($sformatf("v%0d_rvalid", n), 32'(core_r_valid), 32'(vecs[n].e_rv));
            for (int c = 0; c < 2; c++) begin
                int eid;
                eid = (c == 0) ? int'(vecs[n].e_id0) : int'(vecs[n].e_id1);
                if (vecs[n].e_freq[c]) begin
                    check($sformatf("v%0d_op%0d", n, c), 32'(fpu_op[c]), 32'(op_of(eid)));
                    check($sformatf("v%0d_flag%0d", n, c), 32'(fpu_flag[c]), 32'(flag_of(eid)));
                    check($sformatf("v%0d_opnd%0d", n, c), fpu_operands[c][2], opnd_of(eid, 2));
                end
            end
            @(posedge clk);
            #1;
        end

        // Reset while channel 0 holds a request and core 0 is at its limit
        load_core_data(1'b0);
        core_req    = 8'h04;
        fpu_gnt     = 2'b11;
        fpu_r_valid = 2'b00;
        @(negedge clk);
        check("pre_rst_gnt", 32'(core_gnt), 32'h04);
        @(posedge clk);
        #1;
        check("pre_rst_freq0", 32'(fpu_req[0]), 32'h1);
        check("pre_rst_id0", 32'(fpu_id[0]), 32'h2);
        rst_n       = 1'b0;
        fpu_r_valid = 2'b01;
        fpu_r_id[0] = 3'd2;
        #1;
        check("in_rst_freq", 32'(fpu_req), 32'h0);
        check("in_rst_gnt", 32'(core_gnt), 32'h0);
        check("in_rst_rvalid", 32'(core_r_valid), 32'h0);
        check("in_rst_id0", 32'(fpu_id[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        fpu_r_valid = 2'b00;
        core_req    = 8'h14;
        rst_n       = 1'b1;
        #1;
        check("post_rst_ptr0", 32'(core_gnt), 32'h04);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_next", 32'(core_gnt), 32'h10);
        check("post_rst_id0", 32'(fpu_id[0]), 32'h2);
        check("post_rst_freq", 32'(fpu_req), 32'h1);
        @(posedge clk);
        #1;
        core_req = 8'h01;
        @(negedge clk);
        check("cnt_clr_gnt1", 32'(core_gnt), 32'h01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cnt_clr_gnt2", 32'(core_gnt), 32'h01);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("cnt_clr_max", 32'(core_gnt), 32'h00);
        core_req = 8'h00;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
